// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake plus transmitter-side signals shared by the arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters' and transmitter's view.
interface uart_tx_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [2:0] baud_cfg;
    logic       ack0;
    logic       ack1;
    logic       done0;
    logic       done1;
    logic       err;
    logic       busy;
    logic       send_en;
    logic [7:0] data_byte;
    logic [2:0] baud_set;
    logic       tx_done;

    modport slave (
        input  req0, req1, data0, data1, baud_cfg, tx_done,
        output ack0, ack1, done0, done1, err, busy, send_en, data_byte, baud_set
    );

    modport master (
        output req0, req1, data0, data1, baud_cfg, tx_done,
        input  ack0, ack1, done0, done1, err, busy, send_en, data_byte, baud_set
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that lets two requesters share one uart_byte_tx.
// It has a WAIT-state watchdog and an optional idle gap after each frame.
module uart_tx_arbiter #(
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 600000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    uart_tx_arbiter_if.slave      bus_if
);

    localparam int unsigned     WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      baud_q, baud_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            send_q, send_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0]      gap_q, gap_d;
    logic            grant1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            data_q  <= '0;
            baud_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            wd_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            send_q  <= send_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
        end
    end

    // On a tie, grant the requester that was not served last.
    assign grant1 = bus_if.req1 & (~bus_if.req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        data_d  = data_q;
        baud_d  = baud_q;
        busy_d  = busy_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;
        send_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_if.req0 || bus_if.req1) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    data_d  = grant1 ? bus_if.data1 : bus_if.data0;
                    baud_d  = bus_if.baud_cfg;
                    ack0_d  = ~grant1;
                    ack1_d  = grant1;
                    send_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_if.tx_done) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_if.ack0      = ack0_q;
    assign bus_if.ack1      = ack1_q;
    assign bus_if.done0     = done0_q;
    assign bus_if.done1     = done1_q;
    assign bus_if.err       = err_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.send_en   = send_q;
    assign bus_if.data_byte = data_q;
    assign bus_if.baud_set  = baud_q;

endmodule
